mips_debug_ctrl: RTL and testbench

- Sequencer that owns execution control of the mips pipeline: run, single-step, stop, CPU reset.
- Dumps cycle count, register file and data memory as a byte stream.
- Sits between a byte-oriented host link (UART RX/TX wrappers) and the CPU top.
- Drives the pipeline's global advance enable, a CPU reset, and the register-file/data-memory debug read ports.

---
 rtl/mips_debug_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mips_debug_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_ctrl.sv
// Execution-control sequencer for the mips pipeline: run/step/stop/CPU reset plus a
// byte-stream dump of cycle count, register file and data memory. Optional macro: DBG_AUTO_DUMP_EN.
module mips_debug_ctrl #(
  parameter int MEM_WORDS  = 32,
  parameter int MEM_AW     = 5,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cmd_valid,
  input  logic [7:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_halt,
  output logic              o_cpu_en,
  output logic              o_cpu_reset,
  output logic [4:0]        o_dbg_reg_addr,
  input  logic [31:0]       i_dbg_reg_data,
  output logic [MEM_AW-1:0] o_dbg_mem_addr,
  input  logic [31:0]       i_dbg_mem_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [31:0]       o_cycle_count,
  output logic              o_halted
);

  localparam int NWORDS = 33 + MEM_WORDS;
  localparam int WW     = $clog2(NWORDS + 1);
  localparam int RCW    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [WW-1:0]  LAST_WORD = WW'(NWORDS - 1);
  localparam logic [RCW-1:0] RST_LOAD  = RCW'(RST_CYCLES - 1);

  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_STOP  = 8'h48;
  localparam logic [7:0] CMD_DUMP  = 8'h44;
  localparam logic [7:0] CMD_CPURST = 8'h43;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_CPU_RST,
    S_DUMP_ADDR,
    S_DUMP_LOAD,
    S_DUMP_SEND
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_cmd_ready;
  logic [31:0]      r_cycle_count;
  logic             r_halted;
  logic [RCW-1:0]   r_rst_cnt;
  logic [WW-1:0]    r_word;
  logic [1:0]       r_byte;
  logic [31:0]      r_shift;
  logic [4:0]       r_reg_addr;
  logic [MEM_AW-1:0] r_mem_addr;
  logic             r_src_mem;

  logic             w_accept;
  logic             w_cpu_en;
  logic             w_tx_hs;
  logic             w_start_dump;
  logic             w_start_rst;
  logic             w_set_halt;
  logic [31:0]      w_count_next;
  logic [WW-1:0]    w_word_inc;

  assign w_accept     = i_cmd_valid && r_cmd_ready;
  assign w_cpu_en     = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_tx_hs      = (r_state == S_DUMP_SEND) && i_tx_ready;
  assign w_count_next = (w_cpu_en && (r_cycle_count != 32'hFFFF_FFFF)) ?
                        r_cycle_count + 32'd1 : r_cycle_count;
  assign w_word_inc   = r_word + WW'(1);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_start_dump = 1'b0;
    w_start_rst  = 1'b0;
    w_set_halt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (i_cmd)
            CMD_RUN:    if (!r_halted) w_next_state = S_RUN;
            CMD_STEP:   if (!r_halted) w_next_state = S_STEP;
            CMD_DUMP:   w_start_dump = 1'b1;
            CMD_CPURST: begin
              w_start_rst  = 1'b1;
              w_next_state = S_CPU_RST;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (i_halt) begin
          w_set_halt = 1'b1;
`ifdef DBG_AUTO_DUMP_EN
          w_start_dump = 1'b1;
`else
          w_next_state = S_IDLE;
`endif
        end else if (w_accept && (i_cmd == CMD_STOP)) begin
          w_next_state = S_IDLE;
        end
      end
      S_STEP: begin
        w_set_halt = i_halt;
`ifdef DBG_AUTO_DUMP_EN
        w_start_dump = 1'b1;
`else
        w_next_state = S_IDLE;
`endif
      end
      S_CPU_RST: begin
        if (r_rst_cnt == '0) w_next_state = S_IDLE;
      end
      S_DUMP_ADDR: w_next_state = S_DUMP_LOAD;
      S_DUMP_LOAD: w_next_state = S_DUMP_SEND;
      S_DUMP_SEND: begin
        if (w_tx_hs && (r_byte == 2'd3)) begin
          w_next_state = (r_word == LAST_WORD) ? S_IDLE : S_DUMP_ADDR;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    // The cycle-count word is already in hand, so it goes straight to the sender.
    if (w_start_dump) w_next_state = S_DUMP_SEND;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_cycle_count <= '0;
      r_halted      <= 1'b0;
      r_rst_cnt     <= '0;
      r_word        <= '0;
      r_byte        <= '0;
      r_shift       <= '0;
      r_reg_addr    <= '0;
      r_mem_addr    <= '0;
      r_src_mem     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cmd_ready <= (w_next_state == S_IDLE) || (w_next_state == S_RUN);

      if (w_start_rst) begin
        r_cycle_count <= '0;
        r_halted      <= 1'b0;
        r_rst_cnt     <= RST_LOAD;
      end else begin
        r_cycle_count <= w_count_next;
        if (w_set_halt) r_halted <= 1'b1;
        if ((r_state == S_CPU_RST) && (r_rst_cnt != '0)) r_rst_cnt <= r_rst_cnt - RCW'(1);
      end

      if (w_start_dump) begin
        r_shift <= w_count_next;
        r_byte  <= '0;
        r_word  <= '0;
      end else if (r_state == S_DUMP_LOAD) begin
        r_shift <= r_src_mem ? i_dbg_mem_data : i_dbg_reg_data;
        r_byte  <= '0;
      end else if (w_tx_hs) begin
        r_shift <= {8'h00, r_shift[31:8]};
        r_byte  <= r_byte + 2'd1;
        if ((r_byte == 2'd3) && (r_word != LAST_WORD)) begin
          r_word <= w_word_inc;
          // Words 1..32 are registers 0..31; the rest are memory words from 0.
          if (w_word_inc <= WW'(32)) begin
            r_reg_addr <= 5'(w_word_inc - WW'(1));
            r_src_mem  <= 1'b0;
          end else begin
            r_mem_addr <= MEM_AW'(w_word_inc - WW'(33));
            r_src_mem  <= 1'b1;
          end
        end
      end
    end
  end

  assign o_cmd_ready    = r_cmd_ready;
  assign o_cpu_en       = w_cpu_en;
  assign o_cpu_reset    = (r_state == S_CPU_RST);
  assign o_tx_valid     = (r_state == S_DUMP_SEND);
  assign o_tx_data      = r_shift[7:0];
  assign o_cycle_count  = r_cycle_count;
  assign o_halted       = r_halted;
  assign o_dbg_reg_addr = r_reg_addr;
  assign o_dbg_mem_addr = r_mem_addr;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed bench for mips_debug_ctrl: command table plus hand sequences for dump,
// stop, reset-mid-dump and step-triggered dump behaviour.
module tb_mips_debug_ctrl;

  localparam int NBYTES = 4 * (33 + 32);
`ifdef DBG_AUTO_DUMP_EN
  localparam int AUTO_BYTES = NBYTES;
`else
  localparam int AUTO_BYTES = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_cmd_valid;
  logic [7:0]  i_cmd;
  logic        o_cmd_ready;
  logic        i_halt;
  logic        o_cpu_en;
  logic        o_cpu_reset;
  logic [4:0]  o_dbg_reg_addr;
  logic [31:0] i_dbg_reg_data;
  logic [4:0]  o_dbg_mem_addr;
  logic [31:0] i_dbg_mem_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] o_cycle_count;
  logic        o_halted;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mips_debug_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .i_cmd_valid    (i_cmd_valid),
    .i_cmd          (i_cmd),
    .o_cmd_ready    (o_cmd_ready),
    .i_halt         (i_halt),
    .o_cpu_en       (o_cpu_en),
    .o_cpu_reset    (o_cpu_reset),
    .o_dbg_reg_addr (o_dbg_reg_addr),
    .i_dbg_reg_data (i_dbg_reg_data),
    .o_dbg_mem_addr (o_dbg_mem_addr),
    .i_dbg_mem_data (i_dbg_mem_data),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (i_tx_ready),
    .o_cycle_count  (o_cycle_count),
    .o_halted       (o_halted)
  );

  // Synchronous-read register file and memory models
  always @(posedge clk) begin
    i_dbg_reg_data <= 32'h0000_0100 + {27'd0, o_dbg_reg_addr};
    i_dbg_mem_data <= 32'hA000_0000 + {27'd0, o_dbg_mem_addr};
  end

  typedef struct {
    logic [7:0]  cmd;
    int          halt_after;
    int          exp_en;
    int          exp_rst;
    logic [31:0] exp_count;
    logic        exp_halted;
    bit          dumps;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic [7:0] c);
    int w = 0;
    while (!o_cmd_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_before_send", {31'd0, o_cmd_ready}, 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd       = 8'h00;
  endtask

  function automatic logic [31:0] exp_word(input int w);
    if (w == 0)       return 32'd5;
    else if (w <= 32) return 32'h0000_0100 + 32'(w - 1);
    else              return 32'hA000_0000 + 32'(w - 33);
  endfunction

  initial begin
    int n_en, n_rst, n_tx, cyc, got, extra;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic [7:0]  exp_b;
    logic [31:0] w;
    logic [31:0] first_word;

    vecs[0]  = '{8'h53, 0,  1, 0, 32'd1,  1'b0, 1'b1};
    vecs[1]  = '{8'h53, 0,  1, 0, 32'd2,  1'b0, 1'b1};
    vecs[2]  = '{8'h53, 0,  1, 0, 32'd3,  1'b0, 1'b1};
    vecs[3]  = '{8'h48, 0,  0, 0, 32'd3,  1'b0, 1'b0};
    vecs[4]  = '{8'h58, 0,  0, 0, 32'd3,  1'b0, 1'b0};
    vecs[5]  = '{8'h43, 0,  0, 2, 32'd0,  1'b0, 1'b0};
    vecs[6]  = '{8'h52, 10, 10, 0, 32'd10, 1'b1, 1'b1};
    vecs[7]  = '{8'h52, 0,  0, 0, 32'd10, 1'b1, 1'b0};
    vecs[8]  = '{8'h53, 0,  0, 0, 32'd10, 1'b1, 1'b0};
    vecs[9]  = '{8'h43, 0,  0, 2, 32'd0,  1'b0, 1'b0};
    vecs[10] = '{8'h53, 0,  1, 0, 32'd1,  1'b0, 1'b1};
    vecs[11] = '{8'h53, 0,  1, 0, 32'd2,  1'b0, 1'b1};
    vecs[12] = '{8'h53, 0,  1, 0, 32'd3,  1'b0, 1'b1};
    vecs[13] = '{8'h53, 0,  1, 0, 32'd4,  1'b0, 1'b1};
    vecs[14] = '{8'h53, 0,  1, 0, 32'd5,  1'b0, 1'b1};

    reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = 8'h00; i_halt = 1'b0; i_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cpu_en",    {31'd0, o_cpu_en},    32'd0);
    check("rst_cpu_reset", {31'd0, o_cpu_reset}, 32'd0);
    check("rst_tx_valid",  {31'd0, o_tx_valid},  32'd0);
    check("rst_tx_data",   {24'd0, o_tx_data},   32'd0);
    check("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
    check("rst_count",     o_cycle_count,        32'd0);
    check("rst_halted",    {31'd0, o_halted},    32'd0);
    check("rst_reg_addr",  {27'd0, o_dbg_reg_addr}, 32'd0);
    check("rst_mem_addr",  {27'd0, o_dbg_mem_addr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, o_cmd_ready}, 32'd1);

    // Command table: send, watch until quiet, compare totals.
    for (int v = 0; v < 15; v++) begin
      send_cmd(vecs[v].cmd);
      n_en = 0; n_rst = 0; n_tx = 0; cyc = 0;
      while ((cyc < 30 || !o_cmd_ready) && cyc < 3000) begin
        if (o_cpu_en) n_en++;
        if (o_cpu_reset) n_rst++;
        if (o_tx_valid && i_tx_ready) n_tx++;
        i_halt = (vecs[v].halt_after != 0) && o_cpu_en && (n_en == vecs[v].halt_after);
        @(negedge clk);
        cyc++;
      end
      i_halt = 1'b0;
      check($sformatf("vec%0d_settle", v), {31'd0, o_cmd_ready}, 32'd1);
      check($sformatf("vec%0d_en_cycles", v), 32'(n_en), 32'(vecs[v].exp_en));
      check($sformatf("vec%0d_rst_cycles", v), 32'(n_rst), 32'(vecs[v].exp_rst));
      check($sformatf("vec%0d_count", v), o_cycle_count, vecs[v].exp_count);
      check($sformatf("vec%0d_halted", v), {31'd0, o_halted}, {31'd0, vecs[v].exp_halted});
      check($sformatf("vec%0d_tx_bytes", v), 32'(n_tx), vecs[v].dumps ? 32'(AUTO_BYTES) : 32'd0);
    end

    // Full dump with a randomly stalling sink.
    send_cmd(8'h44);
    check("dump_first_latency", {31'd0, o_tx_valid}, 32'd1);
    got = 0; cyc = 0; n_en = 0; extra = 0; prev_stall = 1'b0; prev_data = 8'h00;
    while (got < NBYTES && cyc < 5000) begin
      if (o_cpu_en) n_en++;
      if (prev_stall && (!o_tx_valid || o_tx_data !== prev_data)) extra++;
      i_tx_ready = 1'($urandom_range(0, 1));
      if (o_tx_valid && i_tx_ready) begin
        w     = exp_word(got / 4);
        exp_b = w[8*(got%4) +: 8];
        check($sformatf("dump_byte%0d", got), {24'd0, o_tx_data}, {24'd0, exp_b});
        got++;
      end
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data  = o_tx_data;
      @(negedge clk);
      cyc++;
    end
    check("dump_byte_total", 32'(got), 32'(NBYTES));
    check("dump_stall_stable_violations", 32'(extra), 32'd0);
    check("dump_cpu_en_cycles", 32'(n_en), 32'd0);
    i_tx_ready = 1'b1;
    n_tx = 0;
    repeat (20) begin
      if (o_tx_valid) n_tx++;
      @(negedge clk);
    end
    check("dump_no_extra_bytes", 32'(n_tx), 32'd0);
    check("dump_ready_after", {31'd0, o_cmd_ready}, 32'd1);

    // Run stopped by 'H': five enabled cycles on top of the count of 5.
    send_cmd(8'h52);
    repeat (4) @(negedge clk);
    send_cmd(8'h48);
    check("stop_cpu_en", {31'd0, o_cpu_en}, 32'd0);
    check("stop_count", o_cycle_count, 32'd10);
    check("stop_halted", {31'd0, o_halted}, 32'd0);
    repeat (5) @(negedge clk);
    check("stop_count_frozen", o_cycle_count, 32'd10);

    // Reset while byte 37 of a dump is on offer.
    send_cmd(8'h44);
    got = 0; cyc = 0;
    while (got < 37 && cyc < 1000) begin
      if (o_tx_valid && i_tx_ready) got++;
      @(negedge clk);
      cyc++;
    end
    check("middump_reached", 32'(got), 32'd37);
    i_tx_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("middump_tx_valid", {31'd0, o_tx_valid}, 32'd0);
    check("middump_count", o_cycle_count, 32'd0);
    reset = 1'b0;
    i_tx_ready = 1'b1;
    n_tx = 0;
    repeat (30) begin
      if (o_tx_valid) n_tx++;
      @(negedge clk);
    end
    check("middump_no_more_bytes", 32'(n_tx), 32'd0);
    check("middump_idle_ready", {31'd0, o_cmd_ready}, 32'd1);

    // Single step from a fresh count: dump only when the auto-dump build is selected.
    send_cmd(8'h53);
    n_tx = 0; first_word = '0;
    repeat (800) begin
      if (o_tx_valid && i_tx_ready) begin
        if (n_tx < 4) first_word[8*n_tx +: 8] = o_tx_data;
        n_tx++;
      end
      @(negedge clk);
    end
    check("step_dump_bytes", 32'(n_tx), 32'(AUTO_BYTES));
    check("step_count", o_cycle_count, 32'd1);
`ifdef DBG_AUTO_DUMP_EN
    check("step_dump_first_word", first_word, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
